// File: rtl/frac_mv_search_if.sv
// frac_mv_search_if: row input, flush and result handshake bundle for frac_mv_search.
interface frac_mv_search_if #(
    parameter int PIX_W  = 8,
    parameter int BLK_W  = 8,
    parameter int BLK_H  = 8,
    parameter int CAND_X = 3,
    parameter int CAND_Y = 3,
    parameter int MV_W   = 3
);
    localparam int NC    = CAND_X * CAND_Y;
    localparam int IDX_W = NC > 1 ? $clog2(NC) : 1;
    localparam int SAD_W = PIX_W + $clog2(BLK_W * BLK_H);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [BLK_W*PIX_W-1:0]    ref_row;
    logic [NC*BLK_W*PIX_W-1:0] cand_rows;
    logic                      out_valid;
    logic                      out_ready;
    logic [MV_W-1:0]           mvx;
    logic [MV_W-1:0]           mvy;
    logic [IDX_W-1:0]          best_idx;
    logic [SAD_W-1:0]          best_sad;
    modport master (
        output flush, in_valid, ref_row, cand_rows, out_ready,
        input  in_ready, out_valid, mvx, mvy, best_idx, best_sad
    );
    modport slave (
        input  flush, in_valid, ref_row, cand_rows, out_ready,
        output in_ready, out_valid, mvx, mvy, best_idx, best_sad
    );
endinterface

// File: rtl/frac_mv_search.sv
// frac_mv_search: per-candidate SAD accumulation over a block, then a sequential minimum scan.
// Define FRAC_MV_COST_EN to compare SAD + COST_LAMBDA*(|mvx|+|mvy|) (saturating) instead of pure SAD.
module frac_mv_search #(
    parameter int PIX_W       = 8,
    parameter int BLK_W       = 8,
    parameter int BLK_H       = 8,
    parameter int CAND_X      = 3,
    parameter int CAND_Y      = 3,
    parameter int MV_W        = 3,
    parameter int COST_LAMBDA = 4
) (
    input logic            clk,
    input logic            reset,
    frac_mv_search_if.slave bus
);
    localparam int NC    = CAND_X * CAND_Y;
    localparam int IDX_W = NC > 1 ? $clog2(NC) : 1;
    localparam int SAD_W = PIX_W + $clog2(BLK_W * BLK_H);
    localparam int CNT_W = $clog2((BLK_H > NC ? BLK_H : NC) + 1);
`ifdef FRAC_MV_COST_EN
    localparam int LAMBDA = COST_LAMBDA;
`else
    localparam int LAMBDA = COST_LAMBDA * 0;
`endif

    typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [SAD_W-1:0] r_acc [NC];
    logic [SAD_W-1:0] w_row_sad [NC];
    logic [SAD_W-1:0] r_min_sad, w_cost, r_best_sad;
    logic [IDX_W-1:0] r_min_idx, w_sel, r_best_idx;
    logic [MV_W-1:0]  r_mvx, r_mvy;
    logic [31:0]      w_sum;
    logic             w_last_row, w_scan_end;

    function automatic int off_x(input int i);
        return i % CAND_X - (CAND_X - 1) / 2;
    endfunction
    function automatic int off_y(input int i);
        return i / CAND_X - (CAND_Y - 1) / 2;
    endfunction
    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction
    function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return a > b ? a - b : b - a;
    endfunction

    assign w_last_row = r_cnt == CNT_W'(BLK_H - 1);
    assign w_scan_end = r_cnt == CNT_W'(NC);
    assign w_sel      = IDX_W'(r_cnt);

    always_comb begin
        for (int c = 0; c < NC; c++) begin
            w_row_sad[c] = '0;
            for (int p = 0; p < BLK_W; p++)
                w_row_sad[c] = w_row_sad[c] + SAD_W'(absdiff(bus.ref_row[p*PIX_W +: PIX_W],
                                                             bus.cand_rows[(c*BLK_W+p)*PIX_W +: PIX_W]));
        end
    end

    // scan-order candidate cost; saturates at the SAD width
    always_comb begin
        w_sum  = 32'(r_acc[w_sel]) + 32'(LAMBDA * (iabs(off_x(int'(w_sel))) + iabs(off_y(int'(w_sel)))));
        w_cost = w_sum > ((32'd1 << SAD_W) - 32'd1) ? '1 : SAD_W'(w_sum);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= bus.flush ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = bus.in_valid ? (BLK_H == 1 ? CMP : ACC) : IDLE;
            ACC:  w_next = bus.in_valid && w_last_row ? CMP : ACC;
            CMP:  w_next = w_scan_end ? DONE : CMP;
            DONE: w_next = bus.out_ready ? IDLE : DONE;
        endcase
    end

    always_comb begin
        bus.in_ready  = r_state == IDLE || r_state == ACC;
        bus.out_valid = r_state == DONE;
    end

    assign bus.mvx      = r_mvx;
    assign bus.mvy      = r_mvy;
    assign bus.best_idx = r_best_idx;
    assign bus.best_sad = r_best_sad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_min_sad  <= '0;
            r_min_idx  <= '0;
            r_best_sad <= '0;
            r_best_idx <= '0;
            r_mvx      <= '0;
            r_mvy      <= '0;
            for (int c = 0; c < NC; c++) r_acc[c] <= '0;
        end else if (bus.flush) begin
            r_cnt <= '0;
            for (int c = 0; c < NC; c++) r_acc[c] <= '0;
        end else if (r_state == IDLE || r_state == ACC) begin
            if (bus.in_valid) begin
                for (int c = 0; c < NC; c++)
                    r_acc[c] <= (r_state == IDLE ? '0 : r_acc[c]) + w_row_sad[c];
                r_cnt <= w_last_row ? '0 : r_cnt + 1'b1;
            end
        end else if (r_state == CMP) begin
            r_cnt <= w_scan_end ? '0 : r_cnt + 1'b1;
            if (w_scan_end) begin
                r_best_sad <= r_min_sad;
                r_best_idx <= r_min_idx;
                r_mvx      <= MV_W'(off_x(int'(r_min_idx)));
                r_mvy      <= MV_W'(off_y(int'(r_min_idx)));
            end else if (r_cnt == '0 || w_cost < r_min_sad) begin
                r_min_sad <= w_cost;
                r_min_idx <= w_sel;
            end
        end
    end
endmodule

// File: doc/frac_mv_search.md
Name: frac_mv_search

Overview:
- Parametrised fractional-pel motion-vector search; the next generation of the team's 8x8 QPEL search.
- Per cycle it takes one row of the reference block plus the same row of every fractional-position candidate block, produced by the upstream interpolation filter.
- Accumulates one SAD per candidate, then scans sequentially for the minimum and returns the signed MV and SAD of the winner.
- Sits between the interpolation filter and the MV/mode-decision stage.

Parameters:
- PIX_W, 8, bits per pixel (unsigned).
- BLK_W, 8, pixels per row.
- BLK_H, 8, rows per block (>=1).
- CAND_X, 3, candidate columns, odd; centre column is MV x = 0.
- CAND_Y, 3, candidate rows, odd; centre row is MV y = 0.
- MV_W, 3, signed width of mvx/mvy.
- COST_LAMBDA, 4, MV cost weight; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous abort of the current block.
- in_valid  in  1  row valid.
- in_ready  out  1  block can accept a row.
- ref_row  in  BLK_W*PIX_W  reference row; pixel 0 in the LSBs.
- cand_rows  in  NC*BLK_W*PIX_W  candidate rows, NC=CAND_X*CAND_Y; candidate 0 in the LSBs.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- mvx  out  MV_W  signed x of the winner.
- mvy  out  MV_W  signed y of the winner.
- best_idx  out  clog2(NC)  winning candidate index.
- best_sad  out  SAD_W  winning SAD (plus cost if enabled); SAD_W = PIX_W+clog2(BLK_W*BLK_H).

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
  - State IDLE, row counter 0, all SAD accumulators 0.
  - in_ready=1 and out_valid=0.
  - mvx, mvy, best_idx and best_sad all 0.
- Candidate index c = cy*CAND_X + cx.
  - mvx = cx - (CAND_X-1)/2 and mvy = cy - (CAND_Y-1)/2, sign-extended to MV_W.
- Row SAD = sum over BLK_W of |ref - cand|, using unsigned absolute difference. Accumulators are SAD_W bits and never overflow.
- IDLE: in_ready=1. On in_valid, accumulator[c] is loaded with row SAD[c], not added, and the counter becomes 1. Next state is ACC, or CMP if BLK_H=1.
- ACC: in_ready=1.
  - Each in_valid cycle adds row SAD[c] and increments the counter.
  - The row that makes the count equal BLK_H moves the FSM to CMP and clears the counter.
  - Cycles with in_valid=0 are bubbles: no state change.
- CMP: in_ready=0.
  - One candidate per cycle, index 0..NC-1, compared with the running minimum; the minimum is seeded by candidate 0.
  - Strictly-less replaces the minimum, so ties keep the lowest index.
  - After the last candidate: register the outputs, set out_valid=1, go to DONE.
  - out_valid rises NC+1 cycles after the edge that accepted the last row.
- DONE: in_ready=0.
  - Outputs and out_valid hold stable while out_ready=0.
  - The out_valid&out_ready edge clears out_valid and returns to IDLE. The next block is accepted from the following cycle.
  - mvx, mvy, best_idx and best_sad keep their last values after the handshake.
- flush=1 at any edge:
  - Forces IDLE and clears the counter and accumulators.
  - Drops any pending result: out_valid goes to 0.
  - flush has priority over a simultaneous in_valid or out_ready.
- reset mid-operation: identical to power-on reset; the partial block is lost.

Optional Feature:
- Macro FRAC_MV_COST_EN.
- Defined: during CMP each candidate is compared as SAD + COST_LAMBDA*(|mvx|+|mvy|). The sum saturates to all-ones at SAD_W, and best_sad reports the cost-included value.
- Undefined: pure SAD comparison; COST_LAMBDA is unused.
- Latency is identical in both builds.

Test Plan:
1. Defaults; candidate 4 equals ref, all others equal ref+1; 8 rows back-to-back -> out_valid 10 cycles after the 8th row; best_idx=4, mvx=0, mvy=0, best_sad=0.
2. All candidates ref+2 except candidate 8 at ref+1 -> best_idx=8, mvx=+1, mvy=+1, best_sad=64. Repeat with in_valid low every other cycle -> identical result.
3. All candidates equal ref (all-tie) -> best_idx=0, mvx=-1, mvy=-1, best_sad=0.
4. Hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; after the handshake in_ready=1 next cycle and a second block returns a correct result.
5. After 3 rows, pulse reset for one cycle; separately, after 3 rows assert flush; separately, assert flush during DONE -> each case returns to IDLE with out_valid=0, and a following full 8-row block returns the correct result.
6. Candidate 0 SAD 0, candidate 4 SAD 4 (one pixel off by 4), others 255 per pixel:
   - without FRAC_MV_COST_EN -> best_idx=0, best_sad=0.
   - with FRAC_MV_COST_EN -> best_idx=4, best_sad=4, since candidate 0 costs 8.
